// File: rtl/ym_psg_pkg.sv
// Shared types and constants for the YM2149 PSG bus master: command record,
// FSM state encoding and the register numbers with special handling.
package ym_psg_pkg;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } psg_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } psg_state_t;

  localparam logic [3:0] REG_ENV_SHAPE = 4'd13;
  localparam logic [3:0] REG_MIXER     = 4'd7;
  localparam logic [7:0] MIXER_RESET   = 8'hFF;
  localparam int         NUM_REGS      = 16;

  // Power-on contents of a PSG register: everything clear except the mixer.
  function automatic logic [7:0] shadow_reset_val(input logic [3:0] addr);
    return (addr == REG_MIXER) ? MIXER_RESET : 8'h00;
  endfunction

endpackage

// File: rtl/ym_psg_cmd_fifo.sv
// Synchronous command FIFO for the PSG master; head entry is visible
// combinationally so the FSM can inspect it in the same cycle it pops.
module ym_psg_cmd_fifo
  import ym_psg_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          i_push,
  input  psg_cmd_t                      i_data,
  input  logic                          i_pop,
  output psg_cmd_t                      o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  psg_cmd_t      r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ym_psg_master.sv
// YM2149 PSG register bus master: queues host commands and issues them one at
// a time with a CE-counted gap. Define YM_PSG_MASTER_DEDUP_EN to drop redundant writes.
module ym_psg_master
  import ym_psg_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CE     = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rd,
  input  logic [3:0]                  cmd_addr,
  input  logic [7:0]                  cmd_data,
  output logic                        rsp_valid,
  output logic [7:0]                  rsp_data,
  output logic                        PSG_CS,
  output logic                        PSG_WR,
  output logic [3:0]                  PSG_ADDR,
  output logic [7:0]                  PSG_DI,
  input  logic [7:0]                  PSG_DO,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int GCW = (GAP_CE > 1) ? $clog2(GAP_CE) : 1;
  localparam logic [GCW-1:0] GAP_LAST = (GAP_CE > 0) ? GCW'(GAP_CE - 1) : '0;

  psg_state_t     r_state;
  logic           r_is_rd;
  logic [GCW-1:0] r_gap_cnt;
  logic           r_cs;
  logic           r_wr;
  logic [3:0]     r_addr;
  logic [7:0]     r_di;
  logic           r_rsp_valid;
  logic [7:0]     r_rsp_data;

  psg_cmd_t       w_cmd_in;
  psg_cmd_t       w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_drop;

  assign w_cmd_in = '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};

  ym_psg_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_pop = (r_state == ST_IDLE) && !w_empty;

`ifdef YM_PSG_MASTER_DEDUP_EN
  logic [7:0] r_shadow [NUM_REGS];

  // R13 is always re-issued because any write to it restarts the envelope.
  assign w_drop = !w_head.rd && (w_head.addr != REG_ENV_SHAPE) &&
                  (r_shadow[w_head.addr] == w_head.data);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= shadow_reset_val(4'(i));
      end
    end else if (w_pop && !w_drop && !w_head.rd) begin
      r_shadow[w_head.addr] <= w_head.data;
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_is_rd     <= 1'b0;
      r_gap_cnt   <= '0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= 4'd0;
      r_di        <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop && !w_drop) begin
            r_state <= ST_ISSUE;
            r_cs    <= 1'b1;
            r_wr    <= !w_head.rd;
            r_addr  <= w_head.addr;
            r_di    <= w_head.rd ? 8'h00 : w_head.data;
            r_is_rd <= w_head.rd;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // PSG_DO is combinational from the PSG, so it is valid for this address now.
          r_cs      <= 1'b0;
          r_wr      <= 1'b0;
          r_gap_cnt <= '0;
          if (r_is_rd) begin
            r_rsp_data  <= PSG_DO;
            r_rsp_valid <= 1'b1;
          end
          r_state <= (GAP_CE > 0) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (CE) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign PSG_CS    = r_cs;
  assign PSG_WR    = r_wr;
  assign PSG_ADDR  = r_addr;
  assign PSG_DI    = r_di;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_ym_psg_master.sv
// Directed bench for ym_psg_master: a GAP_CE=2 instance for most steps and a
// GAP_CE=0 instance for the back-to-back case; bus traffic checked against queues.
module tb_ym_psg_master;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CE = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       v0 = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [3:0] cmd_addr = 4'd0;
  logic [7:0] cmd_data = 8'd0;

  logic       cmd_ready, rsp_valid, PSG_CS, PSG_WR, busy;
  logic [7:0] rsp_data, PSG_DI, PSG_DO;
  logic [3:0] PSG_ADDR, level;
  logic       ready0, rsp_valid0, cs0, wr0, busy0;
  logic [7:0] rsp_data0, di0, do0;
  logic [3:0] addr0, level0;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  bit ce_en = 1'b0;
  int ce_div = 0;
  int ce_cnt = 0;
  bit first_acc = 1'b1;
  int n_bus = 0;
  int n_bus0 = 0;
  int last0 = -1;
  logic [12:0] exp_bus[$];
  logic [12:0] exp_bus0[$];
  logic [7:0]  exp_rsp[$];
`ifdef YM_PSG_MASTER_DEDUP_EN
  logic [7:0] tb_shadow [16];
`endif

  function automatic logic [7:0] psg_model(input logic [3:0] a);
    return (a == 4'd7) ? 8'h5A : {4'hC, a};
  endfunction

  assign PSG_DO = psg_model(PSG_ADDR);
  assign do0    = psg_model(addr0);

  ym_psg_master #(.FIFO_DEPTH(8), .GAP_CE(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .PSG_CS(PSG_CS), .PSG_WR(PSG_WR),
    .PSG_ADDR(PSG_ADDR), .PSG_DI(PSG_DI), .PSG_DO(PSG_DO), .busy(busy), .level(level)
  );

  ym_psg_master #(.FIFO_DEPTH(8), .GAP_CE(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .cmd_valid(v0), .cmd_ready(ready0),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .PSG_CS(cs0), .PSG_WR(wr0),
    .PSG_ADDR(addr0), .PSG_DI(di0), .PSG_DO(do0), .busy(busy0), .level(level0)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // CE pulses every third cycle while enabled.
  initial forever begin
    @(posedge CLK);
    #1;
    cyc_n++;
    CE = ce_en && (ce_div == 0);
    ce_div = (ce_div == 2) ? 0 : ce_div + 1;
  end

  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      first_acc = 1'b1;
      ce_cnt = 0;
      last0 = -1;
    end else begin
      if (PSG_CS) begin
        n_bus++;
        check("bus_expected", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) check("bus_access", {PSG_WR, PSG_ADDR, PSG_DI}, exp_bus.pop_front());
        if (!first_acc) check("gap_ce_min", ce_cnt >= 2, 1);
        first_acc = 1'b0;
        ce_cnt = 0;
      end else begin
        check("wr_idle", PSG_WR, 0);
        if (CE) ce_cnt++;
      end
      if (rsp_valid) begin
        check("rsp_expected", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) check("rsp_data", rsp_data, exp_rsp.pop_front());
      end
      if (cs0) begin
        n_bus0++;
        check("bus0_expected", exp_bus0.size() != 0, 1);
        if (exp_bus0.size() != 0) check("bus0_access", {wr0, addr0, di0}, exp_bus0.pop_front());
        if (last0 >= 0) check("gap0_period", cyc_n - last0, 2);
        last0 = cyc_n;
      end
      if (rsp_valid0) check("rsp0_spurious", rsp_valid0, 0);
    end
  end

  task automatic push(input bit sel, input bit rd, input logic [3:0] a, input logic [7:0] d);
    int n;
    bit drop;
    cmd_rd = rd;
    cmd_addr = a;
    cmd_data = d;
    if (sel) v0 = 1'b1;
    else cmd_valid = 1'b1;
    n = 0;
    while ((sel ? !ready0 : !cmd_ready) && n < 200) begin
      tick();
      n++;
    end
    check("push_accept", n < 200, 1);
    @(posedge CLK);
    drop = 1'b0;
`ifdef YM_PSG_MASTER_DEDUP_EN
    if (!sel && !rd) begin
      if (a != 4'd13 && tb_shadow[a] == d) drop = 1'b1;
      else tb_shadow[a] = d;
    end
`endif
    if (sel) exp_bus0.push_back({!rd, a, rd ? 8'h00 : d});
    else if (!drop) exp_bus.push_back({!rd, a, rd ? 8'h00 : d});
    if (!sel && rd) exp_rsp.push_back(psg_model(a));
    #1;
    cmd_valid = 1'b0;
    v0 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_bus0.size() != 0 || exp_rsp.size() != 0 ||
            busy || busy0) && n < 500) begin
      tick();
      n++;
    end
    check("drain", n < 500, 1);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    exp_bus.delete();
    exp_bus0.delete();
    exp_rsp.delete();
`ifdef YM_PSG_MASTER_DEDUP_EN
    for (int i = 0; i < 16; i++) tb_shadow[i] = (i == 7) ? 8'hFF : 8'h00;
`endif
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    do_reset();
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_cs", PSG_CS, 0);
    check("rst_wr", PSG_WR, 0);
    check("rst_addr", PSG_ADDR, 0);
    check("rst_di", PSG_DI, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);

    // Single write with latency check: push in N, ISSUE in N+2.
    ce_en = 1'b1;
    push(0, 0, 4'd8, 8'h1F);
    tick();
    check("latency_cs", PSG_CS, 1);
    drain();
    check("hold_addr", PSG_ADDR, 8);
    check("hold_di", PSG_DI, 8'h1F);
    check("idle_cs", PSG_CS, 0);

    // Read of R7.
    push(0, 1, 4'd7, 8'hEE);
    drain();
    check("rsp_hold", rsp_data, 8'h5A);

    // Backpressure: leader stalls in GAP with CE low while 8 more fill the FIFO.
    ce_en = 1'b0;
    push(0, 0, 4'd1, 8'h11);
    for (int i = 0; i < 8; i++) push(0, (i % 3) == 1, 4'(2 + i), 8'(8'h20 + i));
    check("bp_level_full", level, 8);
    check("bp_ready_low", cmd_ready, 0);
    check("bp_busy", busy, 1);
    ce_en = 1'b1;
    begin
      int n;
      n = 0;
      while (level == 4'd8 && n < 100) begin
        tick();
        n++;
      end
    end
    check("bp_level_pop", level, 7);
    check("bp_ready_back", cmd_ready, 1);
    push(0, 0, 4'd12, 8'h99);
    drain();

    // GAP_CE=0 instance: issues 2 cycles apart.
    push(1, 0, 4'd0, 8'h01);
    push(1, 0, 4'd1, 8'h02);
    push(1, 0, 4'd2, 8'h03);
    drain();
    check("gap0_count", n_bus0, 3);
    check("gap0_level", level0, 0);
    check("dut0_rsp_data", rsp_data0, 0);

    // Reset during GAP with three commands queued.
    ce_en = 1'b0;
    push(0, 0, 4'd9, 8'h11);
    push(0, 1, 4'd7, 8'h00);
    push(0, 0, 4'd10, 8'h22);
    push(0, 0, 4'd11, 8'h33);
    check("mid_level", level, 3);
    do_reset();
    check("mid_rst_level", level, 0);
    check("mid_rst_cs", PSG_CS, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    ce_en = 1'b1;
    repeat (20) tick();

    // Redundant-write filtering (all writes reach the bus when disabled).
    n_bus = 0;
    push(0, 0, 4'd7, 8'hFF);
    push(0, 0, 4'd13, 8'h0A);
    push(0, 0, 4'd13, 8'h0A);
    push(0, 0, 4'd0, 8'h10);
    push(0, 0, 4'd0, 8'h10);
    drain();
`ifdef YM_PSG_MASTER_DEDUP_EN
    check("dedup_count", n_bus, 3);
`else
    check("dedup_count", n_bus, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ym_psg_master.md
Name: ym_psg_master

Overview:
- Bus initiator for the embedded YM2149 PSG register interface: CS/WR/ADDR/DI out, DO in.
- Accepts register write/read commands from a host (sound CPU bridge or HPS), queues them in a small FIFO, and issues them one at a time.
- Enforces a minimum spacing between bus accesses, measured in PSG CE pulses.
- Returns read data on a response strobe. Sits between the host glue and the PSG instance in the audio subsystem.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
- GAP_CE, 2, CE pulses to wait after each bus access before the next one; 0 means back-to-back issue.

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset
- CE  in  1  PSG clock enable; the same signal that drives the PSG
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_rd  in  1  1 = read, 0 = write
- cmd_addr  in  4  PSG register number 0-15
- cmd_data  in  8  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse; rsp_data valid
- rsp_data  out  8  read result
- PSG_CS  out  1  chip select to PSG
- PSG_WR  out  1  write strobe to PSG
- PSG_ADDR  out  4  register address to PSG
- PSG_DI  out  8  write data to PSG
- PSG_DO  in  8  combinational read data from PSG
- busy  out  1  FIFO non-empty or FSM not IDLE
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: RESET is synchronous, active-high; CLK is the clock. RESET clears the FIFO and sets the FSM to IDLE. Reset values: PSG_CS=0, PSG_WR=0, PSG_ADDR=0, PSG_DI=0, rsp_valid=0, rsp_data=0, level=0, busy=0, cmd_ready=1 from the first cycle after reset. RESET asserted mid-operation aborts the access in progress; no response is produced for it.
- Accept: a command is pushed when cmd_valid & cmd_ready. cmd_ready = !full; it is registered-free (derived from current occupancy). Push and pop in the same cycle are legal and leave level unchanged. When full, cmd_ready=0 even if a pop happens that cycle; the freed slot shows as ready on the next cycle.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head and go to ISSUE.
  - ISSUE: lasts exactly one CLK cycle, independent of CE. PSG_CS=1, PSG_WR=!rd, PSG_ADDR=addr, PSG_DI=data (0 for reads). For a read, PSG_DO is sampled into rsp_data at the end of this cycle, and rsp_valid pulses on the following cycle. Next state is GAP if GAP_CE>0, otherwise IDLE.
  - GAP: count CE pulses; after GAP_CE pulses go to IDLE. CE high during the ISSUE cycle does not count.
- Bus idle: outside ISSUE, PSG_CS=0 and PSG_WR=0; PSG_ADDR and PSG_DI hold their last values.
- Latency: push in cycle N into an empty FIFO gives IDLE in N+1 and ISSUE in N+2. Minimum issue period is 2 cycles when GAP_CE=0 (ISSUE, IDLE).
- Ordering: strict FIFO order; reads and writes are never reordered.
- Address wrap: only 4 address bits exist, so there is no out-of-range case.

Optional Feature:
- Macro: YM_PSG_MASTER_DEDUP_EN.
- With the macro: keep a 16x8 shadow of last-written values. Shadow reset values are 0 for all registers except R7=8'hFF, matching PSG reset.
  - A popped write whose data equals the shadow entry is dropped: FSM goes IDLE to IDLE, no ISSUE, no GAP.
  - Writes to R13 are never dropped, because writing R13 restarts the envelope.
  - Reads are never dropped and do not update the shadow.
- Without the macro: every command reaches the bus, and no shadow storage exists.

Decomposition:
- Package ym_psg_pkg:
  - typedef psg_cmd_t (rd, addr[3:0], data[7:0])
  - REG_ENV_SHAPE=4'd13, REG_MIXER=4'd7, MIXER_RESET=8'hFF, NUM_REGS=16
- Sub-module ym_psg_cmd_fifo: synchronous FIFO of psg_cmd_t with push, pop, full, empty and level outputs, parameterised by FIFO_DEPTH.

Test Plan:
- Single write: after reset, push write R8=8'h1F with GAP_CE=2 → exactly one cycle with CS=1, WR=1, ADDR=8, DI=1F; next access no earlier than 2 CE pulses later.
- Read: PSG model drives DO=8'h5A for ADDR=7; push read R7 → one CS=1, WR=0 cycle; rsp_valid pulse the next cycle with rsp_data=5A.
- Backpressure: push 9 commands back-to-back with FIFO_DEPTH=8 and CE held low → cmd_ready falls after 8 pushes; level reaches 8, 7 after first pop; 9th command accepted only after a pop; bus order matches push order.
- GAP_CE=0: push writes R0=01, R1=02, R2=03 → ISSUE cycles exactly 2 CLK apart.
- Reset mid-operation: assert RESET during GAP with 3 commands queued → level=0, CS=0, no rsp_valid, cmd_ready=1 the next cycle.
- DEDUP_EN: write R7=FF, R13=0A twice, R0=10 twice → bus sees R13 twice and R0 once, R7 not at all.
